// File: rtl/bin_bbox_pkg.sv
// Shared constants for the binary bounding-box detector.
package bin_bbox_pkg;

  // Default coordinate width: up to 2047 pixels per line / lines per frame.
  localparam int DEF_COORD_W = 11;

  // Default width of the saturating foreground pixel counter.
  localparam int DEF_CNT_W = 22;

  // Bit of the 8-bit binary pixel that marks foreground (0xFF vs 0x00).
  localparam int FG_BIT = 7;

  // Reset patterns for the min/max trackers, shown at the default width.
  // Their bit 0 is replicated so they scale to any COORD_W:
  // min trackers start at all ones, max trackers start at zero.
  localparam logic [DEF_COORD_W-1:0] COORD_MAX_INIT = '1;
  localparam logic [DEF_COORD_W-1:0] COORD_MIN_INIT = '0;

endpackage : bin_bbox_pkg

// File: rtl/bbox_coord_cnt.sv
// Coordinate generator: normalises vsync, detects frame start and line end,
// and produces saturating pixel (x) and line (y) coordinates.
module bbox_coord_cnt #(
  parameter int COORD_W = 11,
  parameter bit VS_POL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               fs,
  output logic               pix_vld
);

  localparam logic [COORD_W-1:0] COORD_SAT = {COORD_W{1'b1}};

  logic               vs;
  logic               le;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // Normalise vsync to active high, then derive frame-start / line-end strobes.
  always_comb begin
    vs      = vsync ^ ~VS_POL;
    fs      = vs & ~vs_q;
    le      = de_q & ~de;
    // A pixel that coincides with frame start is dropped entirely.
    pix_vld = de & ~fs;
  end

  // Next-state for the edge-detect history and the saturating coordinates.
  always_comb begin
    vs_d = vs;
    de_d = de;

    // x follows the active pixel run; the fs-coincident pixel does not advance it.
    if (!de) begin
      x_d = '0;
    end else if (fs) begin
      x_d = x_q;
    end else if (x_q != COORD_SAT) begin
      x_d = x_q + COORD_W'(1);
    end else begin
      x_d = x_q;
    end

    // y restarts on frame start (which wins over a line end in the same cycle).
    if (fs) begin
      y_d = '0;
    end else if (le && (y_q != COORD_SAT)) begin
      y_d = y_q + COORD_W'(1);
    end else begin
      y_d = y_q;
    end
  end

  // State registers for edge detection and coordinate counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      vs_q <= vs_d;
      de_q <= de_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  // The coordinate of the current pixel is the registered counter value.
  always_comb begin
    x = x_q;
    y = y_q;
  end

endmodule : bbox_coord_cnt

// File: rtl/bin_bbox_detect.sv
// Per-frame foreground statistics on a binary video stream: bounding box,
// saturating pixel count and found flag, published once per frame start.
module bin_bbox_detect
  import bin_bbox_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter bit VS_POL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pre_frame_vsync,
  input  logic               pre_frame_hsync,
  input  logic               pre_frame_de,
  input  logic [7:0]         img_bin,
  output logic               bbox_valid,
  output logic               bbox_found,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic [CNT_W-1:0]   fg_count
);

  localparam logic [COORD_W-1:0] MIN_INIT = {COORD_W{COORD_MAX_INIT[0]}};
  localparam logic [COORD_W-1:0] MAX_INIT = {COORD_W{COORD_MIN_INIT[0]}};
  localparam logic [CNT_W-1:0]   CNT_SAT  = {CNT_W{1'b1}};

  logic [COORD_W-1:0] x, y;
  logic               fs, pix_vld, fg;

  // hsync is carried only for interface symmetry; only the MSB of the pixel matters.
  logic unused_inputs;
  assign unused_inputs = pre_frame_hsync ^ (^img_bin);

  bbox_coord_cnt #(
    .COORD_W (COORD_W),
    .VS_POL  (VS_POL)
  ) u_coord (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (pre_frame_vsync),
    .de      (pre_frame_de),
    .x       (x),
    .y       (y),
    .fs      (fs),
    .pix_vld (pix_vld)
  );

  // Accumulators for the frame in progress.
  logic [COORD_W-1:0] x_min_q, x_min_d;
  logic [COORD_W-1:0] x_max_q, x_max_d;
  logic [COORD_W-1:0] y_min_q, y_min_d;
  logic [COORD_W-1:0] y_max_q, y_max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  // Set by the first frame start; before it the accumulators hold a partial frame.
  logic               frame_seen_q, frame_seen_d;

  // Published result registers, held between frame starts.
  logic               valid_q, valid_d;
  logic               pub_found_q, pub_found_d;
  logic [COORD_W-1:0] pub_x_min_q, pub_x_min_d;
  logic [COORD_W-1:0] pub_x_max_q, pub_x_max_d;
  logic [COORD_W-1:0] pub_y_min_q, pub_y_min_d;
  logic [COORD_W-1:0] pub_y_max_q, pub_y_max_d;
  logic [CNT_W-1:0]   pub_cnt_q, pub_cnt_d;

  // Foreground qualification: active, not the dropped fs pixel, MSB set.
  always_comb begin
    fg = pix_vld & img_bin[FG_BIT];
  end

  // Frame start publishes (when a full frame was seen) and reinitialises;
  // otherwise foreground pixels grow the box and the count.
  always_comb begin
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    cnt_d        = cnt_q;
    found_d      = found_q;
    frame_seen_d = frame_seen_q;
    valid_d      = 1'b0;
    pub_found_d  = pub_found_q;
    pub_x_min_d  = pub_x_min_q;
    pub_x_max_d  = pub_x_max_q;
    pub_y_min_d  = pub_y_min_q;
    pub_y_max_d  = pub_y_max_q;
    pub_cnt_d    = pub_cnt_q;

    if (fs) begin
      if (frame_seen_q) begin
        valid_d     = 1'b1;
        pub_found_d = found_q;
        // An empty frame reports an all-zero box rather than the init patterns.
        pub_x_min_d = found_q ? x_min_q : '0;
        pub_x_max_d = found_q ? x_max_q : '0;
        pub_y_min_d = found_q ? y_min_q : '0;
        pub_y_max_d = found_q ? y_max_q : '0;
        pub_cnt_d   = found_q ? cnt_q   : '0;
      end
      x_min_d      = MIN_INIT;
      x_max_d      = MAX_INIT;
      y_min_d      = MIN_INIT;
      y_max_d      = MAX_INIT;
      cnt_d        = '0;
      found_d      = 1'b0;
      frame_seen_d = 1'b1;
    end else if (fg) begin
      if (x < x_min_q) x_min_d = x;
      if (x > x_max_q) x_max_d = x;
      if (y < y_min_q) y_min_d = y;
      if (y > y_max_q) y_max_d = y;
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
      found_d = 1'b1;
    end
  end

  // Accumulator and publish registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min_q      <= MIN_INIT;
      x_max_q      <= MAX_INIT;
      y_min_q      <= MIN_INIT;
      y_max_q      <= MAX_INIT;
      cnt_q        <= '0;
      found_q      <= 1'b0;
      frame_seen_q <= 1'b0;
      valid_q      <= 1'b0;
      pub_found_q  <= 1'b0;
      pub_x_min_q  <= '0;
      pub_x_max_q  <= '0;
      pub_y_min_q  <= '0;
      pub_y_max_q  <= '0;
      pub_cnt_q    <= '0;
    end else begin
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      cnt_q        <= cnt_d;
      found_q      <= found_d;
      frame_seen_q <= frame_seen_d;
      valid_q      <= valid_d;
      pub_found_q  <= pub_found_d;
      pub_x_min_q  <= pub_x_min_d;
      pub_x_max_q  <= pub_x_max_d;
      pub_y_min_q  <= pub_y_min_d;
      pub_y_max_q  <= pub_y_max_d;
      pub_cnt_q    <= pub_cnt_d;
    end
  end

  // Outputs come straight from the publish registers.
  always_comb begin
    bbox_valid = valid_q;
    bbox_found = pub_found_q;
    bbox_x_min = pub_x_min_q;
    bbox_x_max = pub_x_max_q;
    bbox_y_min = pub_y_min_q;
    bbox_y_max = pub_y_max_q;
    fg_count   = pub_cnt_q;
  end

endmodule : bin_bbox_detect

// File: tb/tb_bin_bbox_detect.sv
// Bench for bin_bbox_detect: one instance with active-high vsync and one with
// active-low vsync share the same stimulus and the same expected results.
module tb_bin_bbox_detect;

  localparam int CW    = 11;
  localparam int NW    = 22;
  localparam int RES_W = 1 + 4 * CW + NW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       vs_act = 1'b0;
  logic       hs     = 1'b0;
  logic       de     = 1'b0;
  logic [7:0] img    = 8'h00;

  logic          v_hi, f_hi, v_lo, f_lo;
  logic [CW-1:0] xn_hi, xx_hi, yn_hi, yx_hi, xn_lo, xx_lo, yn_lo, yx_lo;
  logic [NW-1:0] c_hi, c_lo;

  bin_bbox_detect #(.COORD_W(CW), .CNT_W(NW), .VS_POL(1'b1)) dut_hi (
    .clk (clk), .rst_n (rst_n),
    .pre_frame_vsync (vs_act), .pre_frame_hsync (hs), .pre_frame_de (de),
    .img_bin (img),
    .bbox_valid (v_hi), .bbox_found (f_hi),
    .bbox_x_min (xn_hi), .bbox_x_max (xx_hi),
    .bbox_y_min (yn_hi), .bbox_y_max (yx_hi),
    .fg_count (c_hi)
  );

  bin_bbox_detect #(.COORD_W(CW), .CNT_W(NW), .VS_POL(1'b0)) dut_lo (
    .clk (clk), .rst_n (rst_n),
    .pre_frame_vsync (~vs_act), .pre_frame_hsync (hs), .pre_frame_de (de),
    .img_bin (img),
    .bbox_valid (v_lo), .bbox_found (f_lo),
    .bbox_x_min (xn_lo), .bbox_x_max (xx_lo),
    .bbox_y_min (yn_lo), .bbox_y_max (yx_lo),
    .fg_count (c_lo)
  );

  logic [RES_W-1:0] res_hi, res_lo;
  assign res_hi = {f_hi, xn_hi, xx_hi, yn_hi, yx_hi, c_hi};
  assign res_lo = {f_lo, xn_lo, xx_lo, yn_lo, yx_lo, c_lo};

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q_hi[$];
  logic [RES_W-1:0] exp_q_lo[$];
  logic [RES_W-1:0] last_exp = '0;
  logic [RES_W-1:0] e_hi, e_lo;
  int total = 0;
  int bad   = 0;

  function automatic logic [RES_W-1:0] pk(input logic f, input int xmin, input int xmax,
                                          input int ymin, input int ymax, input int cnt);
    return {f, CW'(xmin), CW'(xmax), CW'(ymin), CW'(ymax), NW'(cnt)};
  endfunction

  // Monitor: every valid cycle consumes one expected result per instance.
  always @(negedge clk) begin
    if (v_hi) begin
      total++;
      if (exp_q_hi.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid_hi got=%h", res_hi);
      end else begin
        e_hi = exp_q_hi.pop_front();
        if (res_hi !== e_hi) begin
          bad++;
          $display("FAIL publish_hi got=%h exp=%h", res_hi, e_hi);
        end
      end
    end
    if (v_lo) begin
      total++;
      if (exp_q_lo.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid_lo got=%h", res_lo);
      end else begin
        e_lo = exp_q_lo.pop_front();
        if (res_lo !== e_lo) begin
          bad++;
          $display("FAIL publish_lo got=%h exp=%h", res_lo, e_lo);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic d, input logic f);
    vs_act = v;
    de     = d;
    hs     = d;
    img    = f ? 8'hFF : 8'h00;
    tick();
  endtask

  task automatic blank(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // 8-wide frame; map bit y*8+x marks a foreground pixel.
  task automatic send_frame(input logic [31:0] map, input int rows);
    for (int yy = 0; yy < rows; yy++) begin
      for (int xx = 0; xx < 8; xx++) drive(1'b0, 1'b1, map[yy*8+xx]);
      blank(3);
    end
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    blank(2);
  endtask

  task automatic expect_pub(input logic f, input int xmin, input int xmax,
                            input int ymin, input int ymax, input int cnt);
    last_exp = pk(f, xmin, xmax, ymin, ymax, cnt);
    exp_q_hi.push_back(last_exp);
    exp_q_lo.push_back(last_exp);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q_hi.size() != 0 || exp_q_lo.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (exp_q_hi.size() != 0 || exp_q_lo.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout pending_hi=%0d pending_lo=%0d required=0",
               name, exp_q_hi.size(), exp_q_lo.size());
      exp_q_hi.delete();
      exp_q_lo.delete();
    end
  endtask

  task automatic check_out(input string name, input logic [RES_W-1:0] exp);
    total++;
    if (res_hi !== exp || v_hi !== 1'b0) begin
      bad++;
      $display("FAIL %s_hi got=%h valid=%b exp=%h valid=0", name, res_hi, v_hi, exp);
    end
    total++;
    if (res_lo !== exp || v_lo !== 1'b0) begin
      bad++;
      $display("FAIL %s_lo got=%h valid=%b exp=%h valid=0", name, res_lo, v_lo, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    check_out("reset_state", '0);
    rst_n = 1'b1;
    tick();

    // Partial frame before the first vsync: no publish on that vsync.
    send_frame(32'hFFFF_FFFF, 2);
    vsync_pulse();
    blank(4);
    check_out("first_vs_no_pub", '0);

    // Single foreground pixel at (3,2).
    send_frame(32'h0008_0000, 4);
    expect_pub(1'b1, 3, 3, 2, 2, 1);
    vsync_pulse();
    wait_drain("single_px");
    check_out("single_px_held", last_exp);

    // All-background frame; previous result must hold until its vsync.
    send_frame(32'h0000_0000, 4);
    check_out("hold_before_vs", last_exp);
    expect_pub(1'b0, 0, 0, 0, 0, 0);
    vsync_pulse();
    wait_drain("empty");

    // Corners (0,0) and (7,3).
    send_frame(32'h8000_0001, 4);
    expect_pub(1'b1, 0, 7, 0, 3, 2);
    vsync_pulse();
    wait_drain("corners");

    // Only (5,1): accumulators must have been reinitialised.
    send_frame(32'h0000_2000, 4);
    expect_pub(1'b1, 5, 5, 1, 1, 1);
    // Vsync edge coincides with a foreground de pixel, which must be dropped;
    // the following pixel (still in vsync) is x=0 and counts.
    drive(1'b1, 1'b1, 1'b1);
    for (int xx = 0; xx < 8; xx++) drive(1'b1, 1'b1, xx == 0);
    blank(3);
    wait_drain("reinit");
    send_frame(32'h0000_0000, 3);
    expect_pub(1'b1, 0, 0, 0, 0, 1);
    vsync_pulse();
    wait_drain("fs_pixel");

    // Mid-frame reset with foreground already seen.
    for (int xx = 0; xx < 8; xx++) drive(1'b0, 1'b1, xx == 6);
    blank(3);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", '0);
    blank(2);
    rst_n = 1'b1;
    blank(2);
    send_frame(32'h0000_00FF, 2);
    vsync_pulse();
    blank(4);
    check_out("post_reset_no_pub", '0);
    send_frame(32'h0400_0000, 4);
    expect_pub(1'b1, 2, 2, 3, 3, 1);
    vsync_pulse();
    wait_drain("post_reset");
    check_out("final_held", last_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_bin_bbox_detect
